// File: rtl/or_chk_pkg.sv
// Shared types and default widths for the y == a | b run-time checker.
package or_chk_pkg;

    localparam int unsigned DEF_CNT_W = 16;
    localparam int unsigned DEF_DLY_W = 8;
    localparam int unsigned DEF_TS_W  = 32;

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_ON   = 2'd1,
        S_PEND = 2'd2
    } chk_state_e;

    typedef struct packed {
        logic                 on;
        logic [DEF_DLY_W-1:0] delay;
    } chk_cmd_t;

endpackage

// File: rtl/or_check_monitor_if.sv
// Sampled OR datapath signals plus the enable/disable command handshake.
interface or_check_monitor_if #(
    parameter int unsigned DLY_W = or_chk_pkg::DEF_DLY_W
);
    logic             a;
    logic             b;
    logic             y;
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_on;
    logic [DLY_W-1:0] cmd_delay;

    modport master (
        output a, b, y, cmd_valid, cmd_on, cmd_delay,
        input  cmd_ready
    );

    modport slave (
        input  a, b, y, cmd_valid, cmd_on, cmd_delay,
        output cmd_ready
    );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + W'(1);
        end
    end
endmodule

// File: rtl/or_check_monitor.sv
// Checks y == a | b every cycle while enabled; enable/disable arrive as
// delayed commands, and pass/fail statistics plus the first-fail stamp are kept.
module or_check_monitor
    import or_chk_pkg::*;
#(
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned DLY_W       = DEF_DLY_W,
    parameter int unsigned TS_W        = DEF_TS_W,
    parameter logic        EN_AT_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    or_check_monitor_if.slave     mon,
    input  logic                  clr,
    output logic                  chk_en,
    output logic [CNT_W-1:0]      pass_cnt,
    output logic [CNT_W-1:0]      fail_cnt,
    output logic                  fail_pulse,
    output logic                  first_fail_vld,
    output logic [TS_W-1:0]       first_fail_ts
);
    localparam chk_state_e RST_STATE = EN_AT_RESET ? S_ON : S_OFF;

    chk_state_e       state_q, state_d;
    logic [DLY_W-1:0] dly_q, dly_d;
    logic             target_q, target_d;
    logic             prev_en_q, prev_en_d;
    logic [TS_W-1:0]  cyc;
    logic             sample_ok, pass_inc, fail_inc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= RST_STATE;
            dly_q     <= '0;
            target_q  <= 1'b0;
            prev_en_q <= EN_AT_RESET;
        end else begin
            state_q   <= state_d;
            dly_q     <= dly_d;
            target_q  <= target_d;
            prev_en_q <= prev_en_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        dly_d     = dly_q;
        target_d  = target_q;
        prev_en_d = prev_en_q;
        case (state_q)
            S_OFF, S_ON: begin
                if (mon.cmd_valid) begin
                    state_d   = S_PEND;
                    dly_d     = mon.cmd_delay;
                    target_d  = mon.cmd_on;
                    prev_en_d = (state_q == S_ON);
                end
            end
            S_PEND: begin
                if (dly_q == '0) begin
                    state_d = target_q ? S_ON : S_OFF;
                end else begin
                    dly_d = dly_q - DLY_W'(1);
                end
            end
            default: state_d = RST_STATE;
        endcase
    end

    // While pending, the old enable stays visible until the delay expires.
    assign chk_en        = (state_q == S_ON) || ((state_q == S_PEND) && prev_en_q);
    assign mon.cmd_ready = (state_q != S_PEND);

    assign sample_ok = (mon.y == (mon.a | mon.b));
    assign pass_inc  = chk_en && sample_ok;
    assign fail_inc  = chk_en && !sample_ok;

    sat_counter #(.W(CNT_W)) u_pass_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .inc   (pass_inc),
        .q     (pass_cnt)
    );

    sat_counter #(.W(CNT_W)) u_fail_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .inc   (fail_inc),
        .q     (fail_cnt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cyc            <= '0;
            fail_pulse     <= 1'b0;
            first_fail_vld <= 1'b0;
            first_fail_ts  <= '0;
        end else begin
            cyc        <= cyc + TS_W'(1);
            fail_pulse <= fail_inc;
            // Clear drops a same-cycle fail from the record; the pulse still fires.
            if (clr) begin
                first_fail_vld <= 1'b0;
                first_fail_ts  <= '0;
            end else if (fail_inc && !first_fail_vld) begin
                first_fail_vld <= 1'b1;
                first_fail_ts  <= cyc;
            end
        end
    end
endmodule
